cp0_unit: RTL and testbench
===========================

CP0_UNIT -- requirements
Module: cp0_unit

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: synchronous, active-high.
- enable, input, 1: CP0 register access strobe.
- Instruction, input, 32: current instruction word.
- PCin, input, 32: PC to save on an exception.
- Din, input, 32: write data.
- ExpSrc0, ExpSrc1, ExpSrc2, input, 1 each: exception sources (2 = highest code).
- PCout, output, 32: EPC contents.
- Dout, output, 32: selected register read data.
- ExRegWrite, output, 1: CP0-write decode.
- ExpBlock, output, 1: global exception mask.
- IsEret, output, 1: ERET decode.
- HasExp, output, 1: exception-taken pulse.

REQ-002 The block SHALL have one clock, clk, and reset SHALL be synchronous and active-high.

Function
REQ-003 ExRegWrite SHALL be combinational and equal to the inverse of Instruction[23].
REQ-004 sel SHALL be Instruction[12:11], selecting a register: 0 = EPC, 1 = Status, 2 = Block, 3 = Cause.
REQ-005 IsEret SHALL be combinational and equal to 1 exactly when Instruction[5:0] = 011000b; all other bits are ignored.
REQ-006 Software write: when enable=1 and ExRegWrite=1 at a rising edge, the register selected by sel SHALL load Din.
- Cause (sel=3) is read-only, and a write to it SHALL be ignored.
REQ-007 Dout SHALL be a combinational mux of {EPC, Status, Block, Cause} by sel, regardless of enable.
REQ-008 PCout SHALL equal EPC combinationally.
REQ-009 ExpBlock SHALL equal Status[0].
- Status bits 31:1 are stored and readable but have no function.
REQ-010 Gated request SHALL be req = (ExpSrc0 AND NOT Block[0]) OR (ExpSrc1 AND NOT Block[1]) OR (ExpSrc2 AND NOT Block[2]).
- Block bits 31:3 are stored only.
REQ-011 Acceptance SHALL occur at a rising edge where:
- req AND NOT ExpBlock = 1,
- that same term was 0 at the previous edge (rising-edge detect, so a held source triggers once), and
- no exception is pending or in its HasExp cycle.
REQ-012 On acceptance, Cause SHALL load {29'b0, ExpSrc2, ExpSrc1|ExpSrc2, ExpSrc0|ExpSrc1|ExpSrc2}, giving 1, 3 or 7, and the pending flag SHALL be set.
- The encoding uses the raw sources, not the Block-gated ones.
REQ-013 HasExp SHALL be registered and high for exactly one clk cycle: the cycle following acceptance.
REQ-014 At the edge ending the HasExp cycle, EPC SHALL load PCin and the pending flag SHALL clear.
REQ-015 HasExp SHALL take priority over a simultaneous software write to EPC; a simultaneous write to Status or Block still occurs.
REQ-016 Requests arriving while pending or during HasExp SHALL be dropped, not queued.
REQ-017 Storage SHALL be built from a reusable 32-bit register submodule, reg32 (sync reset to 0, write enable).
- The pending/edge flags SHALL use a 1-bit set/clear flag submodule, counter1 (sync reset, clear has priority over set).
- Neither submodule may use a derived or gated clock.

Reset
REQ-018 While reset=1 at an edge, the following SHALL clear to 0 and all writes and acceptances SHALL be suppressed:
- EPC, Status, Block and Cause;
- the pending flag;
- the edge-detect history;
- HasExp.
REQ-019 After reset: PCout=0, Dout=0 for every sel, ExpBlock=0, HasExp=0. A reset during the HasExp cycle cancels the EPC update.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset, then read sel 0 to 3 -> Dout=0 each time; PCout=0; HasExp=0.
- Write Status (enable=1, Instruction[23]=0, sel=1, Din=1) -> ExpBlock=1 next cycle. Then pulse ExpSrc0 for one cycle -> HasExp never 1, Cause=0, EPC unchanged.
- Status=0, Block=0, PCin=DEADBEEFh, ExpSrc1 high one cycle -> HasExp high exactly one cycle, then Cause=3 and EPC=PCout=DEADBEEFh.
- Block=7, pulse ExpSrc2 -> no HasExp, Cause unchanged. Then Block=3, pulse ExpSrc2 -> HasExp pulse, Cause=7. ExpSrc0 held high 5 cycles -> exactly one HasExp pulse, Cause=1.
- Write EPC (sel=0, Din=AABBCCDDh) -> PCout=AABBCCDDh. Write sel=3 -> Cause unchanged. Instruction[5:0]=011000b -> IsEret=1; 011001b -> IsEret=0. Instruction[23]=1 -> ExRegWrite=0 and no register changes with enable=1.
- Exception accepted while a write to EPC lands in the HasExp cycle -> EPC=PCin. Assert reset during HasExp -> all registers 0, HasExp=0 next cycle.

Source files
------------

// File: rtl/cp0_unit.sv
// CP0 coprocessor unit: EPC/Status/Block/Cause registers, software access,
// and single-shot exception capture with a one-cycle HasExp pulse.

module reg32 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_i,
    input  logic [31:0] d_i,
    output logic [31:0] q_o
);
    logic [31:0] data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            data_q <= '0;
        else if (we_i)
            data_q <= d_i;
    end

    assign q_o = data_q;
endmodule

module counter1 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic set_i,
    input  logic clr_i,
    output logic q_o
);
    logic flag_q;

    // Clear wins over set.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            flag_q <= 1'b0;
        else if (clr_i)
            flag_q <= 1'b0;
        else if (set_i)
            flag_q <= 1'b1;
    end

    assign q_o = flag_q;
endmodule

module cp0_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] Instruction,
    input  logic [31:0] PCin,
    input  logic [31:0] Din,
    input  logic        ExpSrc0,
    input  logic        ExpSrc1,
    input  logic        ExpSrc2,
    output logic [31:0] PCout,
    output logic [31:0] Dout,
    output logic        ExRegWrite,
    output logic        ExpBlock,
    output logic        IsEret,
    output logic        HasExp
);
    logic [1:0]  sel;
    logic        sw_we;
    logic [31:0] epc_q, status_q, block_q, cause_q;
    logic        epc_we;
    logic [31:0] epc_d;
    logic [31:0] cause_d;
    logic        req, trig, accept;
    logic        prev_q, pend_q;
    logic        hasexp_q, hasexp_d;
    logic        instr_unused;

    assign sel        = Instruction[12:11];
    assign ExRegWrite = ~Instruction[23];
    assign IsEret     = (Instruction[5:0] == 6'b011000);
    assign sw_we      = enable & ExRegWrite;
    assign instr_unused = ^{Instruction[31:24], Instruction[22:13], Instruction[10:6]};

    // The HasExp cycle owns EPC, overriding any software write landing on it.
    assign epc_we = hasexp_q | (sw_we & (sel == 2'd0));
    assign epc_d  = hasexp_q ? PCin : Din;

    reg32 u_epc (
        .clk_i (clk),
        .rst_i (reset),
        .we_i  (epc_we),
        .d_i   (epc_d),
        .q_o   (epc_q)
    );

    reg32 u_status (
        .clk_i (clk),
        .rst_i (reset),
        .we_i  (sw_we & (sel == 2'd1)),
        .d_i   (Din),
        .q_o   (status_q)
    );

    reg32 u_block (
        .clk_i (clk),
        .rst_i (reset),
        .we_i  (sw_we & (sel == 2'd2)),
        .d_i   (Din),
        .q_o   (block_q)
    );

    // Cause encodes the raw sources, not the Block-gated ones.
    assign cause_d = {29'b0, ExpSrc2, ExpSrc1 | ExpSrc2, ExpSrc0 | ExpSrc1 | ExpSrc2};

    reg32 u_cause (
        .clk_i (clk),
        .rst_i (reset),
        .we_i  (accept),
        .d_i   (cause_d),
        .q_o   (cause_q)
    );

    assign ExpBlock = status_q[0];
    assign req      = (ExpSrc0 & ~block_q[0]) | (ExpSrc1 & ~block_q[1]) | (ExpSrc2 & ~block_q[2]);
    assign trig     = req & ~ExpBlock;
    assign accept   = trig & ~prev_q & ~pend_q & ~hasexp_q;

    counter1 u_prev (
        .clk_i (clk),
        .rst_i (reset),
        .set_i (trig),
        .clr_i (~trig),
        .q_o   (prev_q)
    );

    counter1 u_pend (
        .clk_i (clk),
        .rst_i (reset),
        .set_i (accept),
        .clr_i (hasexp_q),
        .q_o   (pend_q)
    );

    assign hasexp_d = accept;

    always_ff @(posedge clk) begin
        if (reset)
            hasexp_q <= 1'b0;
        else
            hasexp_q <= hasexp_d;
    end

    assign HasExp = hasexp_q;
    assign PCout  = epc_q;

    always_comb begin
        Dout = '0;
        case (sel)
            2'd0:    Dout = epc_q;
            2'd1:    Dout = status_q;
            2'd2:    Dout = block_q;
            default: Dout = cause_q;
        endcase
    end
endmodule

// File: tb/tb_cp0_unit.sv
// Bench for cp0_unit: directed scenarios followed by random traffic, all
// checked against a register-array reference model.

module tb_cp0_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] Instruction = 32'h0080_0000;
    logic [31:0] PCin = '0;
    logic [31:0] Din = '0;
    logic        ExpSrc0 = 1'b0, ExpSrc1 = 1'b0, ExpSrc2 = 1'b0;
    logic [31:0] PCout, Dout;
    logic        ExRegWrite, ExpBlock, IsEret, HasExp;

    int errors = 0;
    int checks = 0;

    // Reference state: reg index 0 EPC, 1 Status, 2 Block, 3 Cause.
    logic [31:0] m_reg [4];
    bit          m_has;
    bit          m_prev;

    cp0_unit dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .Instruction (Instruction),
        .PCin        (PCin),
        .Din         (Din),
        .ExpSrc0     (ExpSrc0),
        .ExpSrc1     (ExpSrc1),
        .ExpSrc2     (ExpSrc2),
        .PCout       (PCout),
        .Dout        (Dout),
        .ExRegWrite  (ExRegWrite),
        .ExpBlock    (ExpBlock),
        .IsEret      (IsEret),
        .HasExp      (HasExp)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr(input bit wr, input bit [1:0] s, input bit [5:0] fn);
        logic [31:0] v;
        v = '0;
        v[23] = ~wr;
        v[12:11] = s;
        v[5:0] = fn;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one clock edge to the model using the inputs as currently driven.
    task automatic model_edge();
        bit          trig, acc;
        bit [1:0]    s;
        logic [31:0] code;
        if (reset) begin
            for (int unsigned i = 0; i < 4; i++) m_reg[i] = '0;
            m_has = 0;
            m_prev = 0;
        end else begin
            s = Instruction[12:11];
            trig = ((ExpSrc0 && !m_reg[2][0]) || (ExpSrc1 && !m_reg[2][1]) ||
                    (ExpSrc2 && !m_reg[2][2])) && !m_reg[1][0];
            acc = trig && !m_prev && !m_has;
            code = ExpSrc2 ? 32'd7 : ExpSrc1 ? 32'd3 : ExpSrc0 ? 32'd1 : 32'd0;
            if (enable && !Instruction[23] && s != 2'd3 && !(s == 2'd0 && m_has))
                m_reg[s] = Din;
            if (m_has) m_reg[0] = PCin;
            if (acc) m_reg[3] = code;
            m_prev = trig;
            m_has = acc;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".PCout"}, PCout, m_reg[0]);
        chk({tag, ".Dout"}, Dout, m_reg[Instruction[12:11]]);
        chk({tag, ".ExpBlock"}, {31'b0, ExpBlock}, {31'b0, m_reg[1][0]});
        chk({tag, ".HasExp"}, {31'b0, HasExp}, {31'b0, m_has});
        chk({tag, ".IsEret"}, {31'b0, IsEret}, {31'b0, Instruction[5:0] == 6'b011000});
        chk({tag, ".ExRegWrite"}, {31'b0, ExRegWrite}, {31'b0, ~Instruction[23]});
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic rd(input bit [1:0] s, output logic [31:0] v);
        logic [31:0] save;
        save = Instruction;
        Instruction = instr(1'b0, s, 6'd0);
        #1;
        v = Dout;
        Instruction = save;
    endtask

    task automatic sweep(input string tag);
        logic [31:0] v;
        for (int unsigned i = 0; i < 4; i++) begin
            rd(i[1:0], v);
            chk($sformatf("%s.reg%0d", tag, i), v, m_reg[i]);
        end
    endtask

    task automatic wr(input bit [1:0] s, input logic [31:0] d);
        enable = 1'b1;
        Instruction = instr(1'b1, s, 6'd0);
        Din = d;
        step("wr");
        enable = 1'b0;
        Instruction = instr(1'b0, s, 6'd0);
    endtask

    initial begin
        logic [31:0] v;
        int pulses;
        for (int unsigned i = 0; i < 4; i++) m_reg[i] = '0;
        m_has = 0;
        m_prev = 0;

        // Reset and read back.
        step("rst0");
        step("rst1");
        reset = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            rd(i[1:0], v);
            chk($sformatf("rst.dout%0d", i), v, 32'h0);
        end
        chk("rst.pcout", PCout, 32'h0);
        chk("rst.hasexp", {31'b0, HasExp}, 32'h0);

        // Global mask blocks a source pulse.
        wr(2'd1, 32'h1);
        chk("mask.expblock", {31'b0, ExpBlock}, 32'h1);
        ExpSrc0 = 1'b1;
        step("mask.pulse");
        ExpSrc0 = 1'b0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step("mask.idle");
            if (HasExp) pulses++;
        end
        chk("mask.pulses", pulses, 0);
        rd(2'd3, v);
        chk("mask.cause", v, 32'h0);
        chk("mask.epc", PCout, 32'h0);

        // ExpSrc1 exception captures PCin.
        wr(2'd1, 32'h0);
        wr(2'd2, 32'h0);
        PCin = 32'hDEADBEEF;
        ExpSrc1 = 1'b1;
        step("src1.accept");
        chk("src1.hasexp_hi", {31'b0, HasExp}, 32'h1);
        ExpSrc1 = 1'b0;
        step("src1.end");
        chk("src1.hasexp_lo", {31'b0, HasExp}, 32'h0);
        chk("src1.epc", PCout, 32'hDEADBEEF);
        rd(2'd3, v);
        chk("src1.cause", v, 32'h3);
        step("src1.idle");
        chk("src1.hasexp_idle", {31'b0, HasExp}, 32'h0);

        // Per-source blocking.
        wr(2'd2, 32'h7);
        ExpSrc2 = 1'b1;
        step("blk7.pulse");
        chk("blk7.hasexp", {31'b0, HasExp}, 32'h0);
        ExpSrc2 = 1'b0;
        step("blk7.idle");
        rd(2'd3, v);
        chk("blk7.cause", v, 32'h3);
        wr(2'd2, 32'h3);
        ExpSrc2 = 1'b1;
        step("blk3.pulse");
        chk("blk3.hasexp", {31'b0, HasExp}, 32'h1);
        ExpSrc2 = 1'b0;
        step("blk3.end");
        rd(2'd3, v);
        chk("blk3.cause", v, 32'h7);

        // Held source triggers once.
        wr(2'd2, 32'h0);
        PCin = 32'h1000_0040;
        ExpSrc0 = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step("held.src0");
            if (HasExp) pulses++;
        end
        ExpSrc0 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step("held.idle");
            if (HasExp) pulses++;
        end
        chk("held.pulses", pulses, 1);
        rd(2'd3, v);
        chk("held.cause", v, 32'h1);

        // Direct EPC write, read-only Cause, decodes.
        wr(2'd0, 32'hAABBCCDD);
        chk("epcwr.pcout", PCout, 32'hAABBCCDD);
        wr(2'd3, 32'h1234_5678);
        rd(2'd3, v);
        chk("causewr.ro", v, 32'h1);
        Instruction = instr(1'b0, 2'd0, 6'b011000);
        #1 chk("eret.hit", {31'b0, IsEret}, 32'h1);
        Instruction = instr(1'b0, 2'd0, 6'b011001);
        #1 chk("eret.miss", {31'b0, IsEret}, 32'h0);
        enable = 1'b1;
        Din = 32'h5555_AAAA;
        for (int unsigned i = 0; i < 4; i++) begin
            Instruction = instr(1'b0, i[1:0], 6'd0);
            #1 chk("nowr.exregwrite", {31'b0, ExRegWrite}, 32'h0);
            step("nowr.edge");
        end
        enable = 1'b0;
        chk("nowr.epc", PCout, 32'hAABBCCDD);
        sweep("nowr");

        // EPC write colliding with the HasExp cycle.
        PCin = 32'hCAFEF00D;
        ExpSrc1 = 1'b1;
        step("coll.accept");
        ExpSrc1 = 1'b0;
        chk("coll.hasexp", {31'b0, HasExp}, 32'h1);
        enable = 1'b1;
        Instruction = instr(1'b1, 2'd0, 6'd0);
        Din = 32'h1111_1111;
        step("coll.end");
        enable = 1'b0;
        chk("coll.epc", PCout, 32'hCAFEF00D);

        // Reset during HasExp cancels the EPC update.
        step("rstx.gap");
        PCin = 32'h0BAD_0BAD;
        ExpSrc2 = 1'b1;
        step("rstx.accept");
        ExpSrc2 = 1'b0;
        chk("rstx.hasexp_hi", {31'b0, HasExp}, 32'h1);
        reset = 1'b1;
        step("rstx.edge");
        reset = 1'b0;
        chk("rstx.hasexp_lo", {31'b0, HasExp}, 32'h0);
        chk("rstx.pcout", PCout, 32'h0);
        sweep("rstx");

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            reset       = ($urandom_range(0, 49) == 0);
            enable      = $urandom_range(0, 1);
            Instruction = $urandom;
            Din         = $urandom;
            PCin        = $urandom;
            if ($urandom_range(0, 1)) Din[0] = 1'b0;
            ExpSrc0     = ($urandom_range(0, 3) == 0);
            ExpSrc1     = ($urandom_range(0, 3) == 0);
            ExpSrc2     = ($urandom_range(0, 5) == 0);
            step("rand");
        end
        reset = 1'b0;
        sweep("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
